// File: rtl/sync_fifo_wc_pkg.sv
// Sizing math and configuration legality for the width-converting FIFO.
// The lane ratio and per-side unit counts are derived here from the two data widths.
package sync_fifo_wc_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int narrow_dw(input int wr_dw, input int rd_dw);
        return (wr_dw < rd_dw) ? wr_dw : rd_dw;
    endfunction

    function automatic int wide_dw(input int wr_dw, input int rd_dw);
        return (wr_dw < rd_dw) ? rd_dw : wr_dw;
    endfunction

    function automatic int ratio(input int wr_dw, input int rd_dw);
        return wide_dw(wr_dw, rd_dw) / narrow_dw(wr_dw, rd_dw);
    endfunction

    function automatic int wr_units(input int wr_dw, input int rd_dw);
        return wr_dw / narrow_dw(wr_dw, rd_dw);
    endfunction

    function automatic int rd_units(input int wr_dw, input int rd_dw);
        return rd_dw / narrow_dw(wr_dw, rd_dw);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    function automatic bit cfg_ok(input int depth, input int wr_dw, input int rd_dw);
        return (wide_dw(wr_dw, rd_dw) % narrow_dw(wr_dw, rd_dw) == 0) &&
               is_pow2(ratio(wr_dw, rd_dw)) && is_pow2(depth) &&
               (depth >= 2 * ratio(wr_dw, rd_dw));
    endfunction

endpackage

// File: rtl/sync_fifo_wc_if.sv
// Producer/consumer handshake and status bundle of the width-converting FIFO.
interface sync_fifo_wc_if #(
    parameter int WR_DW = 8,
    parameter int RD_DW = 32,
    parameter int LVL_W = 6
);
    logic             wr_en;
    logic [WR_DW-1:0] din;
    logic             rd_en;
    logic [RD_DW-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [LVL_W-1:0] level;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_wc_sdp_ram_be.sv
// Simple dual-port RAM with per-lane write enables and a registered, resettable read port.
module sync_sdp_ram_be
    import sync_fifo_wc_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int LANE_DW = 8,
    parameter int ROWS    = 8,
    localparam int AW     = clog2(ROWS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [LANES-1:0]              be,
    input  logic [AW-1:0]                 waddr,
    input  logic [LANES-1:0][LANE_DW-1:0] wdata,
    input  logic                          re,
    input  logic [AW-1:0]                 raddr,
    output logic [LANES-1:0][LANE_DW-1:0] rdata
);
    logic [LANES-1:0][LANE_DW-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LANES; i++)
                if (be[i]) mem[waddr][i] <= wdata[i];
        end
    end

    // rdata only moves on a read, so it doubles as the held output word
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sync_fifo_wc.sv
// Single-clock FIFO with asymmetric write/read widths, optional FWFT and level flags.
// Storage rows are one wide word; pointers and level count narrow lanes.
module sync_fifo_wc
    import sync_fifo_wc_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int WR_DW  = 8,
    parameter int RD_DW  = 32,
    parameter int FWFT   = 0,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = 4
) (
    input  logic          clk,
    input  logic          rst,
    sync_fifo_wc_if.slave bus
);
    localparam int NW    = narrow_dw(WR_DW, RD_DW);
    localparam int MW    = wide_dw(WR_DW, RD_DW);
    localparam int RATIO = ratio(WR_DW, RD_DW);
    localparam int WR_U  = wr_units(WR_DW, RD_DW);
    localparam int RD_U  = rd_units(WR_DW, RD_DW);
    localparam int AW    = clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int LSH   = clog2(RATIO);
    localparam int ROWS  = DEPTH / RATIO;
    localparam logic [PW-1:0] FULL_TH = PW'(DEPTH - WR_U);

    if (!cfg_ok(DEPTH, WR_DW, RD_DW)) begin : g_bad_cfg
        $error("sync_fifo_wc: DEPTH and width ratio must be powers of two, DEPTH >= 2*RATIO");
    end

    logic [PW-1:0]    wptr, rptr, level_n;
    logic             wr_acc, rd_acc, ram_re, empty_n;
    logic [RATIO-1:0] be;
    logic [MW-1:0]    wdata, rdata;

    assign wr_acc = bus.wr_en && !bus.full;
    assign rd_acc = bus.rd_en && !bus.empty;

    always_comb begin
        level_n = bus.level;
        if (wr_acc) level_n = level_n + PW'(WR_U);
        if (rd_acc) level_n = level_n - PW'(RD_U);
    end

    if (FWFT != 0) begin : g_fwft
        // The RAM read register is the prefetch slot: empty tracks whether it holds a word.
        logic [PW-1:0] mem_cnt;
        assign mem_cnt = wptr - rptr;
        always_comb begin
            ram_re  = (mem_cnt >= PW'(RD_U)) && (bus.empty || rd_acc);
            empty_n = !ram_re && (bus.empty || rd_acc);
        end
    end else begin : g_std
        always_comb begin
            ram_re  = rd_acc;
            empty_n = level_n < PW'(RD_U);
        end
    end

    if (WR_DW >= RD_DW) begin : g_wr_wide
        assign wdata = bus.din;
        assign be    = '1;
    end else begin : g_wr_narrow
        // Replicate across lanes and let the lane enable pick the slot.
        assign wdata = {RATIO{bus.din}};
        assign be    = RATIO'(1) << wptr[LSH-1:0];
    end

    if (RD_DW >= WR_DW) begin : g_rd_wide
        assign bus.dout = rdata;
    end else begin : g_rd_narrow
        logic [LSH-1:0]             rlane_q;
        logic [RATIO-1:0][NW-1:0]   lanes;
        assign lanes = rdata;
        always_ff @(posedge clk) begin
            if (rst)         rlane_q <= '0;
            else if (ram_re) rlane_q <= rptr[LSH-1:0];
        end
        assign bus.dout = lanes[rlane_q];
    end

    sync_sdp_ram_be #(
        .LANES   (RATIO),
        .LANE_DW (NW),
        .ROWS    (ROWS)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .be    (be),
        .waddr (wptr[AW-1:LSH]),
        .wdata (wdata),
        .re    (ram_re),
        .raddr (rptr[AW-1:LSH]),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr             <= '0;
            rptr             <= '0;
            bus.level        <= '0;
            bus.full         <= 1'b0;
            bus.empty        <= 1'b1;
            bus.almost_full  <= (AF_LVL == 0);
            bus.almost_empty <= 1'b1;
            bus.overflow     <= 1'b0;
            bus.underflow    <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + PW'(WR_U);
            if (ram_re) rptr <= rptr + PW'(RD_U);
            bus.level        <= level_n;
            bus.full         <= (level_n > FULL_TH);
            bus.empty        <= empty_n;
            bus.almost_full  <= (level_n >= PW'(AF_LVL));
            bus.almost_empty <= (level_n <= PW'(AE_LVL));
            if (bus.wr_en && bus.full)  bus.overflow  <= 1'b1;
            if (bus.rd_en && bus.empty) bus.underflow <= 1'b1;
        end
    end
endmodule

// File: doc/sync_fifo_wc.md
# sync_fifo_wc

Single-clock FIFO with asymmetric write/read widths, selectable standard or first-word-fall-through (FWFT) read mode, level reporting, programmable almost-full/almost-empty flags and sticky overflow/underflow error flags. It is the synchronous, generalised successor to the two-clock FIFO, used wherever producer and consumer share a clock but differ in bus width. Typical uses are byte-to-word packing in front of DMA and word-to-byte unpacking in front of serial transmitters.

## Interface
- DEPTH, 32, capacity in narrow words (narrow = min(WR_DW,RD_DW)); power of two, ≥ 2×RATIO
- WR_DW, 8, write data width
- RD_DW, 32, read data width; max/min of WR_DW,RD_DW must be a power-of-two RATIO (1 allowed)
- FWFT, 0, 0 = standard read (1-cycle latency), 1 = first-word-fall-through
- AF_LVL, DEPTH-4, almost_full asserts when level ≥ AF_LVL (narrow units)
- AE_LVL, 4, almost_empty asserts when level ≤ AE_LVL (narrow units)
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- din  in  WR_DW  write data
- rd_en  in  1  read request (pop in FWFT)
- dout  out  RD_DW  read data
- full  out  1  free space < one write word
- empty  out  1  no complete read word available
- almost_full  out  1  level ≥ AF_LVL
- almost_empty  out  1  level ≤ AE_LVL
- level  out  clog2(DEPTH)+1  stored narrow words, including FWFT output register
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Rejected requests change no pointer, level or data; they only set the sticky flag.
- Width units: WR_U = WR_DW/narrow, RD_U = RD_DW/narrow. Each accepted write adds WR_U to level; each accepted read subtracts RD_U. Simultaneous accepted write and read apply both in the same cycle.
- full = (DEPTH − level) < WR_U. empty = level < RD_U.
- Packing is little-endian.
  - Write narrow/read wide: the first written word lands in dout[narrow-1:0].
  - Write wide/read narrow: din[narrow-1:0] is read out first.
- Pointers are in narrow units, width clog2(DEPTH)+1 with a wrap bit. They wrap modulo 2·DEPTH, and no special case applies at the wrap.
- dout holds its last value when no read is accepted (standard mode).
- FWFT: an internal output register prefetches the head word whenever it is empty and memory holds ≥ RD_U units. empty = !output-register-valid. rd_en pops the head, and a refill happens in the same cycle if data is present.
- overflow and underflow are cleared only by rst.
- Reset: pointers = 0, level = 0, dout = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (AF_LVL == 0), overflow = 0, underflow = 0. Reset mid-operation discards all stored data. Inputs are ignored during the cycle rst is sampled high.

## Timing
- All flags and level are registered and reflect accepted operations from the edge at which they are sampled, visible the next cycle.
- Standard mode, write → empty low: 1 cycle. Read latency: dout updates at the edge that accepts rd_en.
- FWFT mode, write into empty FIFO at edge k: dout valid and empty low after edge k+1 (2-cycle latency).
- Full → write possible: the cycle after a read is accepted.
- Back-to-back: with level between the thresholds, one write and one read per cycle are sustained indefinitely.

## Structure
- The shared header/package holds:
  - the clog2 function
  - the RATIO, WR_U and RD_U localparam derivations
  - the parameter legality check (elaboration error on non-power-of-two RATIO or DEPTH)
- Sub-module sync_sdp_ram_be: simple dual-port RAM, rows max(WR_DW,RD_DW) wide, per-narrow-lane write enables, registered read port.
- The top level contains:
  - pointers and level counter
  - flag logic
  - the width-conversion lane mux
  - the optional FWFT prefetch register (generate on FWFT)

## Test plan
- WR_DW=8, RD_DW=32, DEPTH=32, FWFT=0:
  - Write 0x11,0x22,0x33,0x44 → empty falls after the 4th write. One read → dout=0x44332211 next cycle, empty=1.
  - Fill with 32 bytes → full=1, level=32. A 33rd write → data unchanged, overflow=1 and stays 1.
- WR_DW=32, RD_DW=8, FWFT=1: write 0xA1B2C3D4 → dout=0xD4 two cycles later. Pops return 0xC3, 0xB2, 0xA1, then empty=1.
- Read on empty → dout unchanged, underflow=1. Simultaneous write+read at level 16 (RATIO 1) → level stays 16 for 100 cycles, data order preserved across the pointer wrap.
- AF_LVL=28, AE_LVL=4: almost_full rises the cycle level reaches 28. almost_empty falls at level 5 (8-bit both sides).
- rst asserted with level=20 → next cycle level=0, empty=1, flags cleared. A subsequent write/read returns only new data.
